instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Front end of the modified-MIPS pipeline. Owns the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. Next-PC selection handles:
- sequential fetch (PC+4)
- taken branches resolved in EX
- jumps decoded in ID
- hazard-unit stalls

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 16384, instruction memory size in bytes; the legal fetch range is 0 .. IMEM_BYTES-4.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hazard unit; hold PC and IF/ID.
- branch_taken  input  1  EX-stage branch resolved taken.
- branch_target  input  32  EX-stage branch target byte address.
- jump  input  1  ID-stage jump decoded.
- jump_target  input  32  ID-stage jump target byte address.
- imem_addr  output  32  byte address to the instruction memory (= pc).
- imem_data  input  32  word returned combinationally by the instruction memory, big-endian.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc_plus4  output  32  IF/ID PC+4.
- ifid_valid  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  sticky; a misaligned or out-of-range PC was fetched.
- perf_fetched  output  32  count of valid instructions delivered.
- perf_stalls  output  32  count of stall cycles.

## Operation

- pc register. imem_addr = pc, combinational from the register.
- Per-edge priority:
  1. reset
  2. branch_taken
  3. jump
  4. stall
  5. sequential
- reset:
  - pc <= RESET_PC
  - ifid_instr <= 0, ifid_pc_plus4 <= 0, ifid_valid <= 0
  - fetch_fault <= 0, perf counters <= 0
- branch_taken:
  - pc <= branch_target.
  - IF/ID flushed: ifid_instr <= 0 (NOP), ifid_valid <= 0, ifid_pc_plus4 unchanged.
  - Overrides stall and overrides a simultaneous jump, because the EX branch is the older instruction.
- jump (branch_taken low): pc <= jump_target; IF/ID flushed as above. Overrides stall.
- stall (no redirect): pc and all IF/ID fields hold their values.
- Sequential:
  - pc <= pc + 4, modulo 2^32.
  - ifid_instr <= imem_data, ifid_pc_plus4 <= pc + 4, ifid_valid <= 1.
- Fault fetch: a PC is faulty if pc[1:0] != 0 or pc > IMEM_BYTES-4.
  - On a sequential advance from a faulty PC, capture NOP with ifid_valid <= 0 and set fetch_fault.
  - The PC still advances.
  - fetch_fault stays set until reset.
- Redirect targets are not masked. A misaligned target is fetched and faulted by the rule above.

## Timing

- Fetch latency: one cycle. The word at pc appears on ifid_instr the edge after pc is presented.
- Redirect penalty:
  - Asserting branch_taken or jump at edge N puts the target on imem_addr after N.
  - The target's instruction appears in IF/ID after edge N+1.
  - IF/ID holds a bubble between N and N+1.
- stall and a redirect in the same cycle: the redirect takes effect; stall is ignored for that edge.
- reset asserted mid-stream takes effect at the next edge regardless of the other inputs. The first fetch after deassertion is from RESET_PC.
- The PC wraps from 32'hFFFF_FFFC to 0 with no special action; that address is out of range and therefore faults.

## Configuration

- IF_PERF_COUNT_EN defined:
  - perf_fetched increments on every edge that loads ifid_valid <= 1.
  - perf_stalls increments on every edge where stall is high and no redirect or reset occurs.
  - Both counters are 32-bit, wrap silently, and are cleared by reset.
- IF_PERF_COUNT_EN undefined: the counters are not built, and perf_fetched and perf_stalls are tied to 0.

## Test plan

- Reset, then release and run 4 cycles:
  - imem_addr sequence 0, 4, 8, 12.
  - ifid_pc_plus4 sequence 4, 8, 12.
  - ifid_valid = 1 from the second edge onward.
- Stall held 3 cycles at pc = 8:
  - imem_addr stays 8 and IF/ID is unchanged.
  - With the macro defined, perf_stalls = 3.
- branch_taken = 1 with branch_target = 100 and jump = 1 with jump_target = 540 in the same cycle, at pc = 20:
  - pc becomes 100, ifid_valid = 0, ifid_instr = 0.
  - The next edge loads mem[100..103] with ifid_pc_plus4 = 104.
- jump to 540 while stall = 1:
  - pc becomes 540 and the bubble is inserted.
  - The following edge delivers word 32'h0CC5202A when stall is low.
- Redirect to 6 (misaligned):
  - Next edge: ifid_valid = 0 and fetch_fault = 1.
  - pc advances to 10.
  - fetch_fault stays 1 until reset.
- Redirect to IMEM_BYTES (16384): the fault asserts. Assert reset mid-run: all outputs return to their reset values on that edge and pc returns to RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module   : instruction_fetch_stage
// Purpose  : Owns the PC, addresses the instruction memory and fills IF/ID.
//            Define IF_PERF_COUNT_EN to build the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);

  localparam logic [31:0] c_LAST_FETCH_ADDR = 32'(IMEM_BYTES - 4);
  localparam logic [31:0] c_NOP             = 32'h0000_0000;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] w_pc_plus4;
  logic        w_pc_bad;
  logic        w_redirect;

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_pc_bad   = (pc_q[1:0] != 2'b00) || (pc_q > c_LAST_FETCH_ADDR);
  assign w_redirect = branch_taken | jump;

  // The EX-stage branch is older than the ID-stage jump, so it wins.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    if (branch_taken) begin
      pc_d    = branch_target;
      instr_d = c_NOP;
      valid_d = 1'b0;
    end else if (jump) begin
      pc_d    = jump_target;
      instr_d = c_NOP;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = w_pc_plus4;
      pc_plus4_d = w_pc_plus4;
      if (w_pc_bad) begin
        instr_d = c_NOP;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end else begin
        instr_d = imem_data;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= c_NOP;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pc_plus4_q;
  assign ifid_valid    = valid_q;
  assign fetch_fault   = fault_q;

`ifdef IF_PERF_COUNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stalls_q, stalls_d;
  logic        w_load_valid;
  logic        w_stall_cycle;

  assign w_load_valid  = !w_redirect && !stall && !w_pc_bad;
  assign w_stall_cycle = !w_redirect && stall;
  assign fetched_d     = fetched_q + {31'd0, w_load_valid};
  assign stalls_d      = stalls_q + {31'd0, w_stall_cycle};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= 32'd0;
      stalls_q  <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_stalls  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module   : tb_instruction_fetch_stage
// Purpose  : Directed vector table plus randomized run against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

  localparam int unsigned c_IMEM_BYTES = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (c_IMEM_BYTES)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_fault   (fetch_fault),
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
  );

  // Instruction memory contents as a pure function of the byte address.
  function automatic logic [31:0] mword(input logic [31:0] a);
    if (a == 32'd540)                    return 32'h0CC5_202A;
    if (a[1:0] != 2'b00 || a > 32'd16380) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  assign imem_data = mword(imem_addr);

  // Reference model of the architectural state.
  logic [31:0] m_pc, m_instr, m_pc4, m_fetched, m_stalls;
  logic        m_valid, m_fault;

  task automatic model_step(input logic rst, input logic st, input logic bt,
                            input logic [31:0] bt_t, input logic j,
                            input logic [31:0] j_t);
    logic bad;
    if (rst) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_fault = 1'b0; m_fetched = 32'd0; m_stalls = 32'd0;
    end else if (bt || j) begin
      m_pc = bt ? bt_t : j_t;
      m_instr = 32'd0;
      m_valid = 1'b0;
    end else if (st) begin
      m_stalls = m_stalls + 1;
    end else begin
      bad = (m_pc % 4 != 0) || (m_pc > c_IMEM_BYTES - 4);
      if (bad) begin
        m_fault = 1'b1; m_instr = 32'd0; m_valid = 1'b0;
      end else begin
        m_instr = mword(m_pc); m_valid = 1'b1; m_fetched = m_fetched + 1;
      end
      m_pc4 = m_pc + 4;
      m_pc  = m_pc + 4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef IF_PERF_COUNT_EN
    chk({tag, " perf_fetched"}, perf_fetched, m_fetched);
    chk({tag, " perf_stalls"}, perf_stalls, m_stalls);
`else
    chk({tag, " perf_fetched"}, perf_fetched, 32'd0);
    chk({tag, " perf_stalls"}, perf_stalls, 32'd0);
`endif
  endtask

  typedef struct {
    logic        rst, st, bt;
    logic [31:0] btgt;
    logic        j;
    logic [31:0] jtgt;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid, e_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic st, input logic bt, input logic [31:0] btgt,
                     input logic j, input logic [31:0] jtgt, input logic [31:0] e_addr,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4,
                     input logic e_valid, input logic e_fault);
    vec_t v;
    v.rst = rst; v.st = st; v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt;
    v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_fault = e_fault;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic rst, input logic st, input logic bt, input logic [31:0] btgt,
                       input logic j, input logic [31:0] jtgt);
    reset = rst; stall = st; branch_taken = bt; branch_target = btgt;
    jump = j; jump_target = jtgt;
    @(posedge clk);
    model_step(rst, st, bt, btgt, j, jtgt);
    #1;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0, 1:    return {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      2:       return {18'd0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
      3:       return 32'd16380;
      4:       return 32'd16384;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    //  rst st bt btgt     j jtgt          addr          instr            pc4    v  f
    add(1, 0, 0, 0,        0, 0,           32'd0,        32'd0,           32'd0,     0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd4,        mword(0),        32'd4,     1, 0);
    add(0, 0, 0, 0,        0, 0,           32'd8,        mword(4),        32'd8,     1, 0);
    add(0, 1, 0, 0,        0, 0,           32'd8,        mword(4),        32'd8,     1, 0);
    add(0, 1, 0, 0,        0, 0,           32'd8,        mword(4),        32'd8,     1, 0);
    add(0, 1, 0, 0,        0, 0,           32'd8,        mword(4),        32'd8,     1, 0);
    add(0, 0, 0, 0,        0, 0,           32'd12,       mword(8),        32'd12,    1, 0);
    add(0, 0, 0, 0,        0, 0,           32'd16,       mword(12),       32'd16,    1, 0);
    add(0, 0, 0, 0,        0, 0,           32'd20,       mword(16),       32'd20,    1, 0);
    add(0, 0, 1, 100,      1, 540,         32'd100,      32'd0,           32'd20,    0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd104,      mword(100),      32'd104,   1, 0);
    add(0, 1, 0, 0,        1, 540,         32'd540,      32'd0,           32'd104,   0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd544,      32'h0CC5_202A,   32'd544,   1, 0);
    add(0, 0, 1, 6,        0, 0,           32'd6,        32'd0,           32'd544,   0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd10,       32'd0,           32'd10,    0, 1);
    add(0, 0, 0, 0,        0, 0,           32'd14,       32'd0,           32'd14,    0, 1);
    add(0, 0, 0, 0,        1, 16384,       32'd16384,    32'd0,           32'd14,    0, 1);
    add(1, 0, 0, 0,        0, 0,           32'd0,        32'd0,           32'd0,     0, 0);
    add(0, 0, 1, 16384,    0, 0,           32'd16384,    32'd0,           32'd0,     0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd16388,    32'd0,           32'd16388, 0, 1);
    add(0, 0, 0, 0,        0, 0,           32'd16392,    32'd0,           32'd16392, 0, 1);
    add(1, 1, 1, 200,      1, 300,         32'd0,        32'd0,           32'd0,     0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd4,        mword(0),        32'd4,     1, 0);
    add(0, 0, 0, 0,        1, 16380,       32'd16380,    32'd0,           32'd4,     0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd16384,    mword(16380),    32'd16384, 1, 0);
    add(0, 0, 0, 0,        0, 0,           32'd16388,    32'd0,           32'd16388, 0, 1);
    add(1, 0, 0, 0,        0, 0,           32'd0,        32'd0,           32'd0,     0, 0);
    add(0, 0, 0, 0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0,        32'd0,     0, 0);
    add(0, 0, 0, 0,        0, 0,           32'd0,        32'd0,           32'd0,     0, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].bt, vecs[i].btgt, vecs[i].j, vecs[i].jtgt);
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d ifid_instr", i), ifid_instr, vecs[i].e_instr);
      chk($sformatf("vec%0d ifid_pc_plus4", i), ifid_pc_plus4, vecs[i].e_pc4);
      chk($sformatf("vec%0d ifid_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d fetch_fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].e_fault});
      chk_perf($sformatf("vec%0d", i));
    end

`ifdef IF_PERF_COUNT_EN
    // Rerun the three-cycle stall from reset to pin perf_stalls to a constant.
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    repeat (3) apply(0, 1, 0, 0, 0, 0);
    chk("stall3 perf_stalls", perf_stalls, 32'd3);
    chk("stall3 perf_fetched", perf_fetched, 32'd2);
`endif

    apply(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic r, s, b, jj;
      logic [31:0] bt_t, j_t;
      r    = ($urandom_range(0, 99) == 0);
      s    = ($urandom_range(0, 3) == 0);
      b    = ($urandom_range(0, 11) == 0);
      jj   = ($urandom_range(0, 11) == 0);
      bt_t = pick_target();
      j_t  = pick_target();
      apply(r, s, b, bt_t, jj, j_t);
      chk("rnd imem_addr", imem_addr, m_pc);
      chk("rnd ifid_instr", ifid_instr, m_instr);
      chk("rnd ifid_pc_plus4", ifid_pc_plus4, m_pc4);
      chk("rnd ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("rnd fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      chk_perf("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
